// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAM command port between the row-cache fill path
//   (reads) and the output-array drain path (writes). One beat is in flight
//   at a time. Contended bursts are bounded to BURST_LEN beats, with
//   round-robin hand-over between the two requesters.
//
//   Handshake: a requester raises *_req with stable address/data and holds
//   them until its one-cycle *_done pulse. The arbiter raises one SDRAM
//   enable (level) with registered address/data and holds everything until
//   dataRead_sdram=1 while in a command state. dataRead_sdram is ignored in
//   any other state.
//
//   Ports:
//     clk, rst         rising-edge clock, synchronous active-high reset
//     rd_req/rd_addr   read request in; rd_done pulse + rd_data out
//     wr_req/wr_addr/wr_data  write request in; wr_done pulse out
//     read_en_sdram, write_en_sdram, sdram_addr, sdram_wdata  SDRAM command
//     sdram_rdata, dataRead_sdram  SDRAM read data and ack
//     timeout_err      one-cycle pulse on watchdog abort
//     state_dbg        FSM state: 0 IDLE, 1 RD_CMD, 2 WR_CMD, 3 DONE
//
//   Optional feature: define ARB_TIMEOUT_EN to enable the ack watchdog.
//   It aborts a command after TIMEOUT_CYC cycles without an ack. Without
//   the macro a command waits for its ack forever and timeout_err is tied 0.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              read_en_sdram,
  output logic              write_en_sdram,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_wdata,
  input  logic [DATA_W-1:0] sdram_rdata,
  input  logic              dataRead_sdram,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  if (BURST_LEN < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("sdram_port_arbiter: BURST_LEN and TIMEOUT_CYC must be >= 1");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RD_CMD = 2'd1;
  localparam logic [1:0] S_WR_CMD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int              CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] burst_cnt;  // beats given to last_rd's side since it last took over
  logic             last_rd;    // 1: the read side was served last
  logic             cur_rd;     // owner of the beat in flight
  logic             stay;
  logic             grant_rd;
  logic             grant_any;

`ifdef ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign state_dbg = state;

  // Tie-break. A burst count of 0 means no burst is running (only true
  // after reset), so the tie goes away from last_served. Reset leaves
  // last_served at the write side, so the read side wins the first tie.
  always_comb begin
    stay      = (burst_cnt != '0) && (burst_cnt < BURST_MAX);
    grant_any = rd_req | wr_req;
    grant_rd  = rd_req;
    if (rd_req && wr_req) begin
      grant_rd = stay ? last_rd : ~last_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      burst_cnt      <= '0;
      last_rd        <= 1'b0;
      cur_rd         <= 1'b0;
      rd_done        <= 1'b0;
      wr_done        <= 1'b0;
      rd_data        <= '0;
      read_en_sdram  <= 1'b0;
      write_en_sdram <= 1'b0;
      sdram_addr     <= '0;
      sdram_wdata    <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt         <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cur_rd         <= grant_rd;
            sdram_addr     <= grant_rd ? rd_addr : wr_addr;
            read_en_sdram  <= grant_rd;
            write_en_sdram <= ~grant_rd;
            state          <= grant_rd ? S_RD_CMD : S_WR_CMD;
            if (!grant_rd) sdram_wdata <= wr_data;
            // A new owner starts its own burst from zero.
            if (grant_rd != last_rd) burst_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        S_RD_CMD, S_WR_CMD: begin
          if (dataRead_sdram) begin
            if (state == S_RD_CMD) rd_data <= sdram_rdata;
            read_en_sdram  <= 1'b0;
            write_en_sdram <= 1'b0;
            // Done pulses are registered here so they coincide with DONE.
            rd_done        <= cur_rd;
            wr_done        <= ~cur_rd;
            state          <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            read_en_sdram  <= 1'b0;
            write_en_sdram <= 1'b0;
            timeout_err    <= 1'b1;
            state          <= S_IDLE;
            // Mark the aborted side as served with an exhausted burst so
            // the other side wins the next tie.
            last_rd        <= cur_rd;
            burst_cnt      <= BURST_MAX;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          last_rd <= cur_rd;
          if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 16;
  localparam int BURST_LEN   = 4;
  localparam int TIMEOUT_CYC = 8;

  logic              clk;
  logic              rst;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              read_en_sdram;
  logic              write_en_sdram;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wdata;
  logic [DATA_W-1:0] sdram_rdata;
  logic              dataRead_sdram;
  logic              timeout_err;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  // Scoreboard: read data expected back, in issue order.
  logic [DATA_W-1:0] exp_q[$];
  // Reference model: history of granted beats since reset (1 = read).
  logic hist_q[$];

  // Observations returned by the SDRAM-side driver.
  logic              o_seen, o_is_rd, o_stable, o_overlap, o_rdone, o_wdone, o_en_after;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata, o_rdat;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .read_en_sdram(read_en_sdram), .write_en_sdram(write_en_sdram),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
    .sdram_rdata(sdram_rdata), .dataRead_sdram(dataRead_sdram),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    dataRead_sdram = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Who wins when the arbiter next samples (rd, wr): derived from the
  // grant history. The trailing run of same-side grants is the burst length.
  function automatic logic model_pick_rd(input logic rd, input logic wr);
    int   run;
    logic last;
    if (!(rd && wr)) return rd;
    last = (hist_q.size() == 0) ? 1'b0 : hist_q[hist_q.size()-1];
    run  = 0;
    for (int i = hist_q.size() - 1; i >= 0; i--) begin
      if (hist_q[i] != last) break;
      run++;
    end
    return (run > 0 && run < BURST_LEN) ? last : ~last;
  endfunction

  // ---------------- SDRAM-side driver ----------------
  // Waits (bounded) for a command, holds it for 'delay' cycles, acks with
  // 'rdata', then samples the done cycle. Returns at the DONE-cycle negedge.
  task automatic serve_beat(input int delay, input logic [DATA_W-1:0] rdata);
    o_seen = 1'b0; o_is_rd = 1'b0; o_stable = 1'b1; o_overlap = 1'b0;
    o_rdone = 1'b0; o_wdone = 1'b0; o_en_after = 1'b0;
    o_addr = '0; o_wdata = '0; o_rdat = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (read_en_sdram || write_en_sdram) begin
        o_seen = 1'b1;
        break;
      end
    end
    if (!o_seen) return;
    o_is_rd   = read_en_sdram;
    o_addr    = sdram_addr;
    o_wdata   = sdram_wdata;
    o_overlap = read_en_sdram & write_en_sdram;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (read_en_sdram !== o_is_rd || write_en_sdram !== ~o_is_rd ||
          sdram_addr !== o_addr || sdram_wdata !== o_wdata) o_stable = 1'b0;
      if (read_en_sdram && write_en_sdram) o_overlap = 1'b1;
    end
    dataRead_sdram = 1'b1;
    sdram_rdata    = rdata;
    @(negedge clk);
    dataRead_sdram = 1'b0;
    sdram_rdata    = DATA_W'($urandom);
    o_rdone    = rd_done;
    o_wdone    = wr_done;
    o_rdat     = rd_data;
    o_en_after = read_en_sdram | write_en_sdram;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [ADDR_W+2*DATA_W+6:0] outs;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    outs = {rd_done, rd_data, wr_done, read_en_sdram, write_en_sdram, sdram_addr,
            sdram_wdata, timeout_err, state_dbg};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst = 1'b0;
    rd_req = 1'b1; rd_addr = 24'h000010;
    wr_req = 1'b1; wr_addr = 24'h000020; wr_data = 16'h0F0F;
    serve_beat(0, 16'h1111);
    checks++;
    if (o_seen !== 1'b1 || o_is_rd !== 1'b1) begin
      errors++; $display("FAIL reset_first_tie: seen %b is_rd %b expected 1 1", o_seen, o_is_rd);
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h000123;
    serve_beat(1, 16'hBEEF);
    rd_req = 1'b0;
    checks++;
    if (o_seen !== 1'b1 || o_is_rd !== 1'b1 || o_addr !== 24'h000123) begin
      errors++; $display("FAIL single_read_cmd: seen %b rd %b addr %h expected 1 1 000123", o_seen, o_is_rd, o_addr);
    end
    checks++;
    if (o_stable !== 1'b1 || o_overlap !== 1'b0) begin
      errors++; $display("FAIL single_read_hold: stable %b overlap %b expected 1 0", o_stable, o_overlap);
    end
    checks++;
    if (o_rdone !== 1'b1 || o_wdone !== 1'b0 || o_en_after !== 1'b0) begin
      errors++; $display("FAIL single_read_done: rd_done %b wr_done %b en %b expected 1 0 0", o_rdone, o_wdone, o_en_after);
    end
    checks++;
    if (o_rdat !== 16'hBEEF) begin errors++; $display("FAIL single_read_data: got %h expected beef", o_rdat); end
    // Ack outside a command must be ignored and rd_data must hold.
    dataRead_sdram = 1'b1; sdram_rdata = 16'h5555;
    @(negedge clk);
    checks++;
    if (rd_done !== 1'b0 || rd_data !== 16'hBEEF) begin
      errors++; $display("FAIL done_one_cycle: rd_done %b rd_data %h expected 0 beef", rd_done, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_done !== 1'b0 || rd_data !== 16'hBEEF || read_en_sdram !== 1'b0) begin
      errors++; $display("FAIL stray_ack: rd_done %b rd_data %h en %b expected 0 beef 0", rd_done, rd_data, read_en_sdram);
    end
    dataRead_sdram = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_order[10];
    logic got_order[10];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h0A0000;
    wr_req = 1'b1; wr_addr = 24'h0B0000; wr_data = 16'hCAFE;
    for (int b = 0; b < 10; b++) begin
      serve_beat(0, DATA_W'(b));
      got_order[b] = o_is_rd;
      checks++;
      if (o_seen !== 1'b1 || o_is_rd !== exp_order[b] || o_overlap !== 1'b0) begin
        errors++; $display("FAIL contention_beat%0d: seen %b rd %b overlap %b expected 1 %b 0",
                           b, o_seen, o_is_rd, o_overlap, exp_order[b]);
      end
      checks++;
      if (o_rdone !== exp_order[b] || o_wdone !== ~exp_order[b]) begin
        errors++; $display("FAIL contention_done%0d: rd_done %b wr_done %b expected %b %b",
                           b, o_rdone, o_wdone, exp_order[b], ~exp_order[b]);
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_write_stall();
    do_reset();
    wr_req = 1'b1; wr_addr = 24'h00FF00; wr_data = 16'h1234;
    serve_beat(7, 16'h0000);
    wr_req = 1'b0;
    checks++;
    if (o_seen !== 1'b1 || o_is_rd !== 1'b0 || o_addr !== 24'h00FF00 || o_wdata !== 16'h1234) begin
      errors++; $display("FAIL stall_cmd: seen %b rd %b addr %h data %h expected 1 0 00ff00 1234",
                         o_seen, o_is_rd, o_addr, o_wdata);
    end
    checks++;
    if (o_stable !== 1'b1 || o_overlap !== 1'b0) begin
      errors++; $display("FAIL stall_hold: stable %b overlap %b expected 1 0", o_stable, o_overlap);
    end
    checks++;
    if (o_wdone !== 1'b1 || o_rdone !== 1'b0 || o_en_after !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL stall_done: wr_done %b rd_done %b en %b terr %b expected 1 0 0 0",
                         o_wdone, o_rdone, o_en_after, timeout_err);
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h000777;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read_en_sdram) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL midrst_cmd: read_en %b expected 1", seen); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (read_en_sdram !== 1'b0 || rd_done !== 1'b0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL midrst_abort: en %b rd_done %b state %0d expected 0 0 0",
                         read_en_sdram, rd_done, state_dbg);
    end
    rst = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_done !== 1'b0 || read_en_sdram !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: rd_done %b en %b expected 0 0", rd_done, read_en_sdram);
    end
    hist_q.delete();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int   en_cycles;
    logic bad_done;
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h000abc;
    en_cycles = 0; bad_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read_en_sdram) begin en_cycles = 1; break; end
    end
    // The write arrives mid-command; the read must still run to abort.
    wr_req = 1'b1; wr_addr = 24'h000def; wr_data = 16'h7777;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_done || wr_done) bad_done = 1'b1;
      if (!read_en_sdram) break;
      en_cycles++;
    end
    checks++;
    if (en_cycles != TIMEOUT_CYC || timeout_err !== 1'b1 || bad_done !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: en_cycles %0d terr %b done %b expected %0d 1 0",
                         en_cycles, timeout_err, bad_done, TIMEOUT_CYC);
    end
    serve_beat(0, 16'h0000);
    checks++;
    if (o_seen !== 1'b1 || o_is_rd !== 1'b0 || o_wdone !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_next: seen %b rd %b wr_done %b terr %b expected 1 0 1 0",
                         o_seen, o_is_rd, o_wdone, timeout_err);
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    logic held, terr;
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h000abc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read_en_sdram) break;
    end
    held = 1'b1; terr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!read_en_sdram) held = 1'b0;
      if (timeout_err) terr = 1'b1;
    end
    checks++;
    if (held !== 1'b1 || terr !== 1'b0) begin
      errors++; $display("FAIL no_watchdog: held %b terr %b expected 1 0", held, terr);
    end
    serve_beat(0, 16'hA5A5);
    rd_req = 1'b0;
    checks++;
    if (o_rdone !== 1'b1 || o_rdat !== 16'hA5A5) begin
      errors++; $display("FAIL no_watchdog_done: rd_done %b data %h expected 1 a5a5", o_rdone, o_rdat);
    end
  endtask
`endif

  task automatic test_random();
    logic              rd, wr, pick;
    logic [DATA_W-1:0] rdata, exp_d;
    do_reset();
    for (int b = 0; b < 60; b++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      rd_req = rd; rd_addr = ADDR_W'($urandom);
      wr_req = wr; wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
      pick  = model_pick_rd(rd, wr);
      rdata = DATA_W'($urandom);
      if (pick) exp_q.push_back(rdata);
      serve_beat($urandom_range(0, 3), rdata);
      hist_q.push_back(pick);
      checks++;
      if (o_seen !== 1'b1 || o_is_rd !== pick || o_overlap !== 1'b0 || o_stable !== 1'b1) begin
        errors++; $display("FAIL rand_grant%0d: seen %b rd %b overlap %b stable %b expected 1 %b 0 1",
                           b, o_seen, o_is_rd, o_overlap, o_stable, pick);
      end
      checks++;
      if (o_addr !== (pick ? rd_addr : wr_addr) || (!pick && o_wdata !== wr_data)) begin
        errors++; $display("FAIL rand_fields%0d: addr %h wdata %h expected %h %h", b, o_addr, o_wdata,
                           pick ? rd_addr : wr_addr, wr_data);
      end
      checks++;
      if (o_rdone !== pick || o_wdone !== ~pick) begin
        errors++; $display("FAIL rand_done%0d: rd_done %b wr_done %b expected %b %b", b, o_rdone, o_wdone, pick, ~pick);
      end
      if (pick && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (o_rdat !== exp_d) begin errors++; $display("FAIL rand_rdata%0d: got %h expected %h", b, o_rdat, exp_d); end
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; dataRead_sdram = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; sdram_rdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_stall();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
